// File: rtl/pc_gen.sv
// Fetch program counter with next-PC resolution, misaligned-target trap FSM,
// fault capture (epc/badaddr) and an external redirect for trap return.
module pc_gen #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] INITPC   = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100),
  parameter bit              CEXT     = 1'b0
) (
  input  logic            clk,
  input  logic            RST,
  input  logic [5:0]      cuOP,
  input  logic [XLEN-1:0] rs1Read,
  input  logic [XLEN-1:0] signExtend,
  input  logic            Zero,
  input  logic            ALUneg,
  input  logic            iready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_ack,
  output logic [XLEN-1:0] PCaddr,
  output logic [XLEN-1:0] PCplus4,
  output logic            trap,
  output logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] badaddr
);

  localparam logic [5:0] CU_JAL  = 6'd2;
  localparam logic [5:0] CU_JALR = 6'd3;
  localparam logic [5:0] CU_BEQ  = 6'd4;
  localparam logic [5:0] CU_BNE  = 6'd5;
  localparam logic [5:0] CU_BLT  = 6'd6;
  localparam logic [5:0] CU_BGE  = 6'd7;
  localparam logic [5:0] CU_BLTU = 6'd8;
  localparam logic [5:0] CU_BGEU = 6'd9;

  typedef enum logic {StRun, StTrap} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] badaddr_q, badaddr_d;

  logic [XLEN-1:0] seq_tgt;
  logic [XLEN-1:0] rel_tgt;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            taken;
  logic            misaligned;

  assign seq_tgt  = pc_q + XLEN'(4);
  assign rel_tgt  = pc_q + (signExtend << 1);
  assign jalr_sum = rs1Read + signExtend;

  always_comb begin
    taken  = 1'b0;
    target = rel_tgt;
    case (cuOP)
      CU_JAL:  taken = 1'b1;
      CU_JALR: begin
        taken  = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      CU_BEQ:  taken = Zero;
      CU_BNE:  taken = ~Zero;
      CU_BLT,
      CU_BLTU: taken = ALUneg;
      CU_BGE,
      CU_BGEU: taken = ~ALUneg | Zero;
      default: taken = 1'b0;
    endcase
  end

  // With compressed alignment bit 0 is always clear here, so no trap can fire.
  assign misaligned = taken & (CEXT ? target[0] : target[1]);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    badaddr_d = badaddr_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = StRun;
    end else begin
      case (state_q)
        StRun: begin
          if (iready) begin
            if (misaligned) begin
              pc_d      = TRAP_VEC;
              epc_d     = pc_q;
              badaddr_d = target;
              state_d   = StTrap;
            end else begin
              pc_d = taken ? target : seq_tgt;
            end
          end
        end
        StTrap: begin
          pc_d = TRAP_VEC;
          if (trap_ack) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= StRun;
      pc_q      <= INITPC;
      epc_q     <= '0;
      badaddr_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      badaddr_q <= badaddr_d;
    end
  end

  assign PCaddr  = pc_q;
  assign PCplus4 = seq_tgt;
  assign trap    = (state_q == StTrap);
  assign epc     = epc_q;
  assign badaddr = badaddr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: 32-bit word-aligned, 32-bit compressed-aligned
// and 16-bit wrap-around instances driven from one stimulus stream.
module tb_pc_gen;

  localparam logic [5:0] CU_JAL  = 6'd2;
  localparam logic [5:0] CU_JALR = 6'd3;
  localparam logic [5:0] CU_BEQ  = 6'd4;
  localparam logic [5:0] CU_BNE  = 6'd5;
  localparam logic [5:0] CU_BLT  = 6'd6;
  localparam logic [5:0] CU_BGE  = 6'd7;
  localparam logic [5:0] CU_BGEU = 6'd9;
  localparam logic [5:0] CU_ADD  = 6'd27;

  logic        clk = 1'b0;
  logic        RST;
  logic [5:0]  cuOP;
  logic [31:0] rs1Read, signExtend, redirect_pc;
  logic        Zero, ALUneg, iready, redirect_valid, trap_ack;

  logic [31:0] pc_a, pc4_a, epc_a, bad_a;
  logic        trap_a;
  logic [31:0] pc_c, pc4_c, epc_c, bad_c;
  logic        trap_c;
  logic [15:0] pc_s, pc4_s, epc_s, bad_s;
  logic        trap_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .INITPC(32'h0), .TRAP_VEC(32'h100), .CEXT(1'b0)) u_dut (
    .clk(clk), .RST(RST), .cuOP(cuOP), .rs1Read(rs1Read), .signExtend(signExtend),
    .Zero(Zero), .ALUneg(ALUneg), .iready(iready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap_ack(trap_ack), .PCaddr(pc_a), .PCplus4(pc4_a),
    .trap(trap_a), .epc(epc_a), .badaddr(bad_a)
  );

  pc_gen #(.XLEN(32), .INITPC(32'h0), .TRAP_VEC(32'h100), .CEXT(1'b1)) u_dut_c (
    .clk(clk), .RST(RST), .cuOP(cuOP), .rs1Read(rs1Read), .signExtend(signExtend),
    .Zero(Zero), .ALUneg(ALUneg), .iready(iready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap_ack(trap_ack), .PCaddr(pc_c), .PCplus4(pc4_c),
    .trap(trap_c), .epc(epc_c), .badaddr(bad_c)
  );

  pc_gen #(.XLEN(16), .INITPC(16'hFFFC), .TRAP_VEC(16'h0100), .CEXT(1'b0)) u_dut16 (
    .clk(clk), .RST(RST), .cuOP(cuOP), .rs1Read(rs1Read[15:0]),
    .signExtend(signExtend[15:0]), .Zero(Zero), .ALUneg(ALUneg), .iready(iready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc[15:0]),
    .trap_ack(trap_ack), .PCaddr(pc_s), .PCplus4(pc4_s), .trap(trap_s), .epc(epc_s),
    .badaddr(bad_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    RST = 1'b1; cuOP = CU_ADD; rs1Read = '0; signExtend = '0; Zero = 1'b0;
    ALUneg = 1'b0; iready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    trap_ack = 1'b0;
    tick();
    RST = 1'b0;
    check("reset_pc", pc_a, 32'h0);
    check("reset_trap", {31'b0, trap_a}, 32'h0);
    check("reset_epc", epc_a, 32'h0);
    check("reset_badaddr", bad_a, 32'h0);
    check("reset_pc16", {16'h0, pc_s}, 32'h0000_FFFC);

    // Sequential fetch
    iready = 1'b1;
    tick(); check("seq_4", pc_a, 32'h4);
    tick(); check("seq_8", pc_a, 32'h8);
    tick(); check("seq_c", pc_a, 32'hC);
    check("pcplus4_10", pc4_a, 32'h10);
    for (int i = 0; i < 5; i++) tick();
    check("seq_20", pc_a, 32'h20);

    // Stall
    iready = 1'b0;
    tick(); tick();
    check("stall_hold", pc_a, 32'h20);

    // Branches
    iready = 1'b1; cuOP = CU_BEQ; Zero = 1'b1; signExtend = 32'h8;
    tick(); check("beq_taken", pc_a, 32'h30);
    cuOP = CU_BNE;
    tick(); check("bne_not_taken", pc_a, 32'h34);

    // JALR: bit 0 masked; bit 1 set traps only without compressed alignment
    cuOP = CU_JALR; Zero = 1'b0; rs1Read = 32'h1001; signExtend = 32'h2;
    tick();
    check("jalr_cext_pc", pc_c, 32'h1002);
    check("jalr_cext_trap", {31'b0, trap_c}, 32'h0);
    check("jalr_trap", {31'b0, trap_a}, 32'h1);
    check("jalr_trap_pc", pc_a, 32'h100);
    check("jalr_badaddr", bad_a, 32'h1002);
    check("jalr_epc", epc_a, 32'h34);

    // Trap holds regardless of fetch activity
    cuOP = CU_JAL; rs1Read = '0; signExtend = '0;
    tick(); tick(); tick();
    check("trap_hold_pc", pc_a, 32'h100);
    check("trap_hold_flag", {31'b0, trap_a}, 32'h1);

    // Acknowledge: trap clears, PC stays that cycle
    trap_ack = 1'b1; iready = 1'b0;
    tick();
    check("ack_trap", {31'b0, trap_a}, 32'h0);
    check("ack_pc", pc_a, 32'h100);
    trap_ack = 1'b0; iready = 1'b1; cuOP = CU_ADD;
    tick(); check("resume_pc", pc_a, 32'h104);

    // Misaligned JAL with no iready is not evaluated
    cuOP = CU_JAL; signExtend = 32'h1; iready = 1'b0;
    tick();
    check("misal_noready_pc", pc_a, 32'h104);
    check("misal_noready_trap", {31'b0, trap_a}, 32'h0);
    iready = 1'b1;
    tick();
    check("jal_trap", {31'b0, trap_a}, 32'h1);
    check("jal_trap_pc", pc_a, 32'h100);
    check("jal_epc", epc_a, 32'h104);
    check("jal_badaddr", bad_a, 32'h106);

    // Redirect beats trap_ack; fault capture is preserved
    redirect_valid = 1'b1; redirect_pc = 32'h40; trap_ack = 1'b1;
    tick();
    redirect_valid = 1'b0; trap_ack = 1'b0;
    check("redirect_pc", pc_a, 32'h40);
    check("redirect_trap", {31'b0, trap_a}, 32'h0);
    check("redirect_epc", epc_a, 32'h104);

    // trap_ack in RUN is ignored; BLT taken
    trap_ack = 1'b1; cuOP = CU_BLT; ALUneg = 1'b1; signExtend = 32'h20;
    tick(); trap_ack = 1'b0;
    check("blt_taken", pc_a, 32'h80);
    cuOP = CU_BGEU; Zero = 1'b0;
    tick(); check("bgeu_not_taken", pc_a, 32'h84);

    // Trap again, then reset together with redirect
    cuOP = CU_JAL; signExtend = 32'h1; ALUneg = 1'b0;
    tick();
    check("trap2_flag", {31'b0, trap_a}, 32'h1);
    RST = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    RST = 1'b0; redirect_valid = 1'b0;
    check("rst_mid_pc", pc_a, 32'h0);
    check("rst_mid_trap", {31'b0, trap_a}, 32'h0);
    check("rst_mid_epc", epc_a, 32'h0);
    check("rst_mid_badaddr", bad_a, 32'h0);
    check("rst16_pc", {16'h0, pc_s}, 32'h0000_FFFC);

    // 16-bit wrap and BGE taken on Zero despite ALUneg
    cuOP = CU_ADD; signExtend = '0;
    tick();
    check("wrap16_pc", {16'h0, pc_s}, 32'h0);
    cuOP = CU_BGE; ALUneg = 1'b1; Zero = 1'b1; signExtend = 32'h10;
    tick();
    check("bge16_pc", {16'h0, pc_s}, 32'h0020);
    check("bge32_pc", pc_a, 32'h24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised successor to the single-cycle program counter. It holds the fetch PC and resolves next-PC for sequential, jump and branch operations using the existing cuOP encoding. Beyond the current block it adds:
- configurable width and instruction alignment (optional 16-bit compressed alignment);
- misaligned-target trap detection with a trap FSM;
- capture of the faulting PC and the bad target;
- an external redirect port for trap return.

It sits between the control unit/ALU and the instruction memory interface.

Parameters:
XLEN, 32, datapath and PC width in bits.
INITPC, 0, PC value loaded on reset.
TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned-target trap (XLEN bits).
CEXT, 0, 1 = 2-byte instruction alignment legal; 0 = 4-byte alignment required.

Ports:
clk  in  1  clock, all state updates on rising edge.
RST  in  1  synchronous, active-high reset.
cuOP  in  6  control-unit opcode, same cuOPType enumeration as the control unit (CU_LUI=0 … CU_ERROR=38).
rs1Read  in  XLEN  rs1 operand (JALR base).
signExtend  in  XLEN  sign-extended immediate.
Zero  in  1  ALU result zero flag.
ALUneg  in  1  ALU result negative/less-than flag.
iready  in  1  instruction memory ready; PC advances only when high.
redirect_valid  in  1  force PC to redirect_pc (trap return).
redirect_pc  in  XLEN  redirect target.
trap_ack  in  1  trap handler acknowledge; clears trap state.
PCaddr  out  XLEN  current PC.
PCplus4  out  XLEN  PC+4 (link value), combinational from PCaddr.
trap  out  1  misaligned-target trap pending.
epc  out  XLEN  PC of the instruction that produced the bad target.
badaddr  out  XLEN  offending target address.

Behaviour:
- Reset: when RST is high at a clock edge:
  - PCaddr=INITPC; trap=0; epc=0; badaddr=0; state=RUN.
  - RST has priority over every other input.
- FSM states:
  - RUN (normal fetch);
  - TRAP (PC at TRAP_VEC, trap=1, waiting for trap_ack).
- Priority at each edge (after RST):
  1. redirect_valid
  2. state-specific action
- redirect_valid=1 in any state:
  - PC<=redirect_pc; state<=RUN; trap<=0.
  - redirect_pc is not alignment-checked.
  - epc and badaddr hold their values.
- RUN with iready=0: PC holds.
- RUN with iready=1, target computed per cuOP. Branch-taken conditions:
  - CU_JAL: PC+(signExtend<<1).
  - CU_JALR: (rs1Read+signExtend) with bit0 forced to 0.
  - CU_BEQ: taken if Zero.
  - CU_BNE: taken if !Zero.
  - CU_BLT and CU_BLTU: taken if ALUneg.
  - CU_BGE and CU_BGEU: taken if !ALUneg | Zero.
  - Taken branch target: PC+(signExtend<<1). Not taken: PC+4.
  - All other ops, including CU_ERROR: PC+4.
- Arithmetic: all adds are modulo 2^XLEN; wrap-around is silent (e.g. PC=FFFF_FFFC, sequential -> 0000_0000).
- Misalignment check, applied only to taken jump/branch targets (sequential PC+4 is never checked):
  - CEXT=0: target[1]!=0 is misaligned.
  - CEXT=1: target[0]!=0 is misaligned, which is impossible after JALR masking and <<1, so the trap never fires.
- On a misaligned target:
  - PC<=TRAP_VEC; epc<=current PC; badaddr<=target; trap<=1; state<=TRAP.
  - The offending target is never loaded into PC.
- TRAP state:
  - PC holds TRAP_VEC regardless of iready and cuOP.
  - trap stays 1 until trap_ack.
  - trap_ack=1: trap<=0, state<=RUN. PC does not change that cycle; fetch resumes from TRAP_VEC on the next iready.
  - trap_ack in RUN is ignored.
- Simultaneous redirect_valid and trap_ack: redirect wins; the result is the same RUN state with trap=0.
- Misaligned branch with iready=0: no trap; evaluated only when iready=1.
- Latency:
  - PC update takes 1 cycle after the qualifying edge.
  - trap asserts in the same cycle as PC=TRAP_VEC.
- Reset mid-trap: trap, epc and badaddr are cleared; PC=INITPC.

Test Plan:
- Reset/sequential: RST=1 one cycle, then iready=1, cuOP=CU_ADD for 3 cycles -> PCaddr 0, 4, 8, 0xC; PCplus4=0x10.
- Stall and branches:
  - iready=0 for 2 cycles at PC=0x20 -> PC holds at 0x20.
  - Then CU_BEQ, Zero=1, signExtend=0x8 -> PC=0x30.
  - CU_BNE, Zero=1 -> PC=0x34.
- JALR masking: rs1Read=0x1001, signExtend=0x2 -> PC=0x1002 with CEXT=1 and no trap. With CEXT=0: trap=1, PC=0x100, badaddr=0x1002, epc=previous PC.
- Trap hold/ack:
  - In TRAP with iready=1 and cuOP=CU_JAL for 3 cycles -> PC stays 0x100, trap=1.
  - trap_ack=1 -> trap=0; the next iready cycle gives PC=0x104.
- Redirect priority: in TRAP, assert redirect_valid=1 with redirect_pc=0x40 and trap_ack=1 in the same cycle -> PC=0x40, trap=0, state RUN. Separately, assert RST together with redirect_valid -> PC=INITPC.
- Wrap-around and XLEN=16: with INITPC=16'hFFFC, one sequential step -> PC=16'h0000. BGE with ALUneg=1, Zero=1, signExtend=0x10 -> PC=0x0020.
